serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, total operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 8, bits processed per clock; WIDTH SHALL be an integer multiple of SLICE, with SLICE >= 1.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a new operation; sampled only when busy=0.
REQ-006 SHALL have port sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 SHALL have ports a, b  input  WIDTH  operands; sampled with start.
REQ-008 SHALL have port busy  output  1  high while slices are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse when sum/cout/ovf are valid.
REQ-010 SHALL have port sum  output  WIDTH  result, held until the next accepted start.
REQ-011 SHALL have ports cout, ovf  output  1 each  final unsigned carry and signed overflow.

Function
REQ-012 SHALL use NSLICE = WIDTH/SLICE and a 3-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL latch a, b^{WIDTH{sub}}, and carry=sub, clear the slice index and sum, and enter RUN.
REQ-014 In RUN, each edge SHALL add slice idx of the latched operands plus carry, write the result into sum[idx*SLICE +: SLICE], update carry, and increment idx.
REQ-015 After the edge that processes slice NSLICE-1, the FSM SHALL enter DONE; done=1 for exactly that one cycle, and the FSM SHALL then return to IDLE unless start=1.
REQ-016 Latency SHALL be fixed: start sampled at edge E, done high in the cycle after edge E+NSLICE.
REQ-017 busy SHALL be 1 exactly in RUN; start asserted while busy=1 SHALL be ignored with no effect.
REQ-018 A start in the DONE cycle SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-019 cout SHALL be the carry out of the MSB slice; for sub=1, cout=1 means no borrow (a >= b unsigned).
REQ-020 ovf SHALL be 1 when the operand sign bits (after inversion for sub) are equal and differ from sum[WIDTH-1].
REQ-021 sum, cout and ovf SHALL be updated only by RUN-state edges and SHALL be stable from done until the next accepted start.
REQ-022 Wrap-around SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE with idx=0, carry=0, sum=0, cout=0, ovf=0, busy=0, done=0, and latched operands=0.
REQ-024 rst SHALL take priority over start and over an operation in progress; an aborted operation SHALL produce no done pulse.

Configuration
REQ-025 Macro SERIAL_ADDSUB_OVF_EN defined: ovf SHALL be computed per REQ-020.
REQ-026 Macro SERIAL_ADDSUB_OVF_EN undefined: ovf SHALL be tied to 0, and no overflow logic SHALL be synthesised.

Structure
REQ-027 Shared package serial_addsub_pkg SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default WIDTH/SLICE constants.
REQ-028 A single sub-module slice_adder (SLICE-bit ripple add with cin/cout, combinational) SHALL be instantiated once and time-shared across slices.
REQ-029 The slice index counter SHALL be $clog2(NSLICE) bits wide, with a minimum of 1.

Verification
REQ-030 WIDTH=32, SLICE=8, sub=0, a=0x000000FF, b=0x00000001 -> done in the 5th cycle after start; sum=0x00000100, cout=0, ovf=0.
REQ-031 a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, ovf=0; a=0x7FFFFFFF, b=1 -> sum=0x80000000, cout=0, ovf=1 (ovf=0 without SERIAL_ADDSUB_OVF_EN).
REQ-032 sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0; sub=1, a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-033 Start with a=1, b=2, then start again with a=9, b=9 while busy -> second start ignored, sum=3; a start during the DONE cycle with a=4, b=4 -> next done gives sum=8.
REQ-034 rst pulsed for 1 cycle during RUN at idx=2 -> no done, and all outputs are 0 on the next cycle; a subsequent start completes normally.
REQ-035 WIDTH=16, SLICE=4, a=0x0FFF, b=0x0001 -> done in the 5th cycle after start, sum=0x1000; WIDTH=8, SLICE=8 -> done in the 2nd cycle after start.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// ----------------------------------------------------------------------------
// serial_addsub_pkg
// Shared definitions for the serial adder/subtractor:
//   - state_t   : FSM state encoding (IDLE / RUN / DONE)
//   - DEF_WIDTH : default operand/result width
//   - DEF_SLICE : default number of bits processed per clock
//   - idx_width : width of the slice index counter (never below 1 bit)
// ----------------------------------------------------------------------------
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/slice_adder.sv
// ----------------------------------------------------------------------------
// slice_adder
// Purely combinational SLICE-bit ripple-carry adder with carry in/out.
// Ports:
//   a, b  [SLICE-1:0]  addends
//   cin                carry in
//   sum   [SLICE-1:0]  a + b + cin (low SLICE bits)
//   cout               carry out of the top bit
// ----------------------------------------------------------------------------
module slice_adder
    import serial_addsub_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    // Bit-serial ripple; the carry chain lives in a function-local variable
    // so the combinational block has no self-referencing vector.
    function automatic logic [SLICE:0] ripple(input logic [SLICE-1:0] x,
                                              input logic [SLICE-1:0] y,
                                              input logic             c_in);
        logic [SLICE:0] r;
        logic           c;
        r = '0;
        c = c_in;
        for (int i = 0; i < SLICE; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[SLICE] = c;
        return r;
    endfunction

    // Combinational slice sum with carry out in the MSB.
    always_comb begin
        {cout, sum} = ripple(a, b, cin);
    end

endmodule

// File: rtl/serial_addsub.sv
// ----------------------------------------------------------------------------
// serial_addsub
// Multi-cycle adder/subtractor that processes SLICE bits per clock through one
// time-shared slice_adder. Subtraction is a + ~b + 1 (b inverted at latch
// time, initial carry = sub).
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   start          request new operation (accepted in IDLE or DONE)
//   sub            0: a+b, 1: a-b (sampled with start)
//   a, b [WIDTH]   operands (sampled with start)
//   busy           high while slices are being processed (RUN)
//   done           one-cycle pulse when sum/cout/ovf are valid
//   sum  [WIDTH]   result, held until the next accepted start
//   cout           carry out of MSB slice (for sub: 1 = no borrow)
//   ovf            signed overflow
// Build option:
//   SERIAL_ADDSUB_OVF_EN  defined -> ovf computed; undefined -> ovf tied to 0
// ----------------------------------------------------------------------------
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             NSLICE     = WIDTH / SLICE;
    localparam int             IW         = idx_width(NSLICE);
    localparam logic [IW-1:0]  IDX_LAST   = IW'(NSLICE - 1);
    localparam logic [IW-1:0]  IDX_ONE    = IW'(1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    state_t             state_r;
    state_t             state_nx;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [IW-1:0]      idx_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;

    logic               accept_s;
    logic               last_s;
    int                 off_s;
    logic [SLICE-1:0]   op_a_s;
    logic [SLICE-1:0]   op_b_s;
    logic [SLICE-1:0]   add_sum_s;
    logic               add_cout_s;

    // Slice selection and handshake decode for the current cycle.
    always_comb begin
        accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        last_s   = (idx_r == IDX_LAST);
        off_s    = SLICE * int'(idx_r);
        op_a_s   = SLICE'(a_r >> off_s);
        op_b_s   = SLICE'(b_r >> off_s);
    end

    slice_adder #(
        .SLICE (SLICE)
    ) u_slice_adder (
        .a    (op_a_s),
        .b    (op_b_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx = ST_RUN;
                else       state_nx = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_nx = ST_DONE;
                else        state_nx = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_nx = ST_RUN;
                else       state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            ST_IDLE: begin busy = 1'b0; done = 1'b0; end
            ST_RUN:  begin busy = 1'b1; done = 1'b0; end
            ST_DONE: begin busy = 1'b0; done = 1'b1; end
            default: begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    // Operand latch and per-slice accumulation; the masked merge writes
    // sum[idx*SLICE +: SLICE] without a variable part-select.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub;
            idx_r   <= '0;
            sum_r   <= '0;
        end else if (state_r == ST_RUN) begin
            sum_r   <= (sum_r & ~(SLICE_MASK << off_s)) | (WIDTH'(add_sum_s) << off_s);
            carry_r <= add_cout_s;
            idx_r   <= idx_r + IDX_ONE;
            if (last_s) begin
                cout_r <= add_cout_s;
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_r;

    // Signed overflow: operand signs (b already inverted for sub) agree but
    // the result MSB, produced by the last slice, differs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if ((state_r == ST_RUN) && last_s) begin
            ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                     (add_sum_s[SLICE-1] != a_r[WIDTH-1]);
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// ----------------------------------------------------------------------------
// tb_serial_addsub
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops
// and compares on every done pulse. Smaller configurations are checked inline.
// ----------------------------------------------------------------------------
module tb_serial_addsub;

    localparam int W  = 32;
    localparam int S  = 8;
    localparam int NS = W / S;
`ifdef SERIAL_ADDSUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, sub;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout, ovf;

    logic         start16, sub16, busy16, done16, cout16, ovf16;
    logic [15:0]  a16, b16, sum16;
    logic         start8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0]   a8, b8, sum8;

    serial_addsub #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

    serial_addsub #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

    serial_addsub #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // Reference arithmetic: plain modular add/subtract on wide integers.
    function automatic void model(input longint unsigned x, input longint unsigned y,
                                  input bit s, input int w,
                                  output longint unsigned r, output bit c, output bit v);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        if (s) begin
            r = (x - y) & mask;
            c = (x >= y);
            v = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
        end else begin
            r = (x + y) & mask;
            c = ((x + y) > mask);
            v = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
        end
        v = v & OVF_ON;
    endfunction

    // Drive one accepted start (caller guarantees busy=0) and push expectation.
    task automatic issue_exp(input logic [W-1:0] x, input logic [W-1:0] y, input bit s,
                             input logic [W-1:0] es, input bit ec, input bit ev);
        exp_t e;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = ev;
        e.due  = cyc + 1 + NS;
        a = x; b = y; sub = s; start = 1'b1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
        longint unsigned r;
        bit c, v;
        model(longint'(x), longint'(y), s, W, r, c, v);
        issue_exp(x, y, s, W'(r), c, v);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout("wait_idle");
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) timeout("wait_done");
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) timeout("drain");
    endtask

    // Inline check for the narrow configurations: latency counted in cycles
    // after the start edge, then the result fields.
    task automatic run_small(input int w, input longint unsigned x, input longint unsigned y,
                             input bit s);
        longint unsigned r;
        bit c, v;
        int cnt, lat;
        model(x, y, s, w, r, c, v);
        lat = (w == 16) ? 5 : 2;
        if (w == 16) begin a16 = 16'(x); b16 = 16'(y); sub16 = s; start16 = 1'b1; end
        else         begin a8  = 8'(x);  b8  = 8'(y);  sub8  = s; start8  = 1'b1; end
        @(negedge clk);
        start16 = 1'b0;
        start8  = 1'b0;
        cnt = 1;
        while (!((w == 16) ? done16 : done8) && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("latency_w%0d", w), 64'(cnt), 64'(lat));
        if (w == 16) begin
            chk("sum_w16", 64'(sum16), r); chk("cout_w16", 64'(cout16), 64'(c)); chk("ovf_w16", 64'(ovf16), 64'(v));
        end else begin
            chk("sum_w8", 64'(sum8), r); chk("cout_w8", 64'(cout8), 64'(c)); chk("ovf_w8", 64'(ovf8), 64'(v));
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head, and
    // check results stay put while idle.
    exp_t         m_e;
    bit           hold_valid = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout, hold_ovf;

    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else if (done) begin
            if (sbq.size() == 0) begin
                timeout("unexpected_done");
            end else begin
                m_e = sbq.pop_front();
                chk("sum", 64'(sum), 64'(m_e.sum));
                chk("cout", 64'(cout), 64'(m_e.cout));
                chk("ovf", 64'(ovf), 64'(m_e.ovf));
                chk("done_cycle", 64'(cyc), 64'(m_e.due));
                hold_sum = m_e.sum; hold_cout = m_e.cout; hold_ovf = m_e.ovf;
                hold_valid = 1'b1;
            end
        end else if (!busy && hold_valid) begin
            chk("hold_sum", 64'(sum), 64'(hold_sum));
            chk("hold_cout_ovf", {62'd0, cout, ovf}, {62'd0, hold_cout, hold_ovf});
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] corner [5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'h0000_0001};

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        start8  = 1'b0; sub8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-derived expectations.
        issue_exp(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        wait_idle();
        issue_exp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        wait_idle();
        issue_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF_ON);
        wait_idle();
        issue_exp(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_idle();
        issue_exp(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, OVF_ON);
        drain();
        repeat (2) @(negedge clk);

        // Start while busy is ignored; start in the DONE cycle is accepted.
        issue_exp(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0);
        a = 32'd9; b = 32'd9; sub = 1'b0; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done();
        issue_exp(32'd4, 32'd4, 1'b0, 32'd8, 1'b0, 1'b0);
        drain();
        repeat (2) @(negedge clk);

        // Reset mid-operation at idx=2: no done, outputs cleared.
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        repeat (8) @(negedge clk);
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        drain();

        // Randomized traffic: corners mixed with random words, random gaps,
        // occasional ignored starts while busy.
        for (int i = 0; i < 80; i++) begin
            logic [W-1:0] x, y;
            wait_idle();
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            issue(x, y, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        drain();

        // Narrow configurations.
        run_small(16, 64'h0FFF, 64'h0001, 1'b0);
        chk("sum_w16_0fff", 64'(sum16), 64'h1000);
        run_small(8, 64'h7F, 64'h01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_small(16, 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)),
                      1'($urandom_range(0, 1)));
            run_small(8, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
